param_interrupt_controller: RTL

PARAM_INTERRUPT_CONTROLLER -- requirements
Module: param_interrupt_controller

---
 rtl/param_interrupt_controller.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/param_interrupt_controller.sv
// Parameterised vectored interrupt controller: edge/level capture, fixed or
// rotating priority, in-service nesting and a two-pulse acknowledge handshake.
module param_interrupt_controller #(
  parameter int N_IRQ = 8,
  parameter int VEC_W = 8,
  parameter int IDX_W = $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             wr_en,
  input  logic [2:0]       wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [2:0]       rd_addr,
  output logic [31:0]      rd_data,
  input  logic             inta,
  output logic             int_out,
  output logic [VEC_W-1:0] vector_out,
  output logic             vector_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACK1 = 2'd1;
  localparam logic [1:0] S_VEC  = 2'd2;

  localparam logic [IDX_W:0]   NQ   = (IDX_W+1)'(N_IRQ);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_IRQ-1);
  localparam logic [N_IRQ-1:0] ONE  = {{(N_IRQ-1){1'b0}}, 1'b1};

  logic [N_IRQ-1:0] imr, trig, irr, isr, irq_hist;
  logic [VEC_W-1:0] vbase;
  logic [1:0]       mode;
  logic [IDX_W-1:0] ptr, lat_idx;
  logic [1:0]       state;

  // Rank 0 is the index just above the lowest-priority pointer; NQ means "none set".
  function automatic logic [IDX_W:0] top_rank(input logic [N_IRQ-1:0] v,
                                              input logic [IDX_W:0]   base);
    logic [2*N_IRQ-1:0] dbl;
    logic [IDX_W:0]     r;
    dbl = {v, v} >> base;
    r   = NQ;
    for (int k = N_IRQ-1; k >= 0; k--)
      if (dbl[k]) r = (IDX_W+1)'(k);
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] rank2idx(input logic [IDX_W:0] r,
                                                input logic [IDX_W:0] base);
    logic [IDX_W+1:0] j;
    j = {1'b0, r} + {1'b0, base};
    if (j >= {1'b0, NQ}) j = j - {1'b0, NQ};
    return j[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] eff_ptr, win_idx, isr_top, eoi_idx;
  logic [IDX_W:0]   base, cand_r, isr_r;
  logic [N_IRQ-1:0] ack_mask, eoi_mask, ack_clr, eoi_clr, isr_set;
  logic             req, ack_hit, eoi_hit;
  logic             unused_wr;

  assign unused_wr = &{1'b0, wr_data};

  assign eff_ptr  = mode[0] ? ptr : LAST;
  assign base     = (eff_ptr == LAST) ? '0 : {1'b0, eff_ptr} + 1'b1;
  assign cand_r   = top_rank(irr & ~imr, base);
  assign isr_r    = top_rank(isr, base);
  // An empty ISR ranks as NQ, so any candidate beats it.
  assign req      = cand_r < isr_r;
  assign win_idx  = rank2idx(cand_r, base);
  assign isr_top  = rank2idx(isr_r, base);

  assign ack_hit  = (state == S_IDLE) && inta && req;
  assign ack_mask = ONE << win_idx;
  assign ack_clr  = ack_hit ? ack_mask : '0;
  assign isr_set  = (ack_hit && !mode[1]) ? ack_mask : '0;

  // Out-of-range specific indices shift to zero and so never hit.
  assign eoi_idx  = wr_data[8] ? wr_data[IDX_W-1:0] : isr_top;
  assign eoi_mask = ONE << eoi_idx;
  assign eoi_hit  = wr_en && (wr_addr == 3'd4) && |(isr & eoi_mask);
  assign eoi_clr  = eoi_hit ? eoi_mask : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imr      <= '1;
      trig     <= '1;
      vbase    <= '0;
      mode     <= '0;
      irr      <= '0;
      isr      <= '0;
      irq_hist <= '0;
      ptr      <= LAST;
    end else begin
      irq_hist <= irq_in;
      // Edge set is OR-ed after the acknowledge clear so a same-cycle set wins.
      irr <= (~trig & irq_in) | (trig & ((irr & ~ack_clr) | (irq_in & ~irq_hist)));
      isr <= (isr & ~eoi_clr) | isr_set;
      if (mode[0]) begin
        if (ack_hit && mode[1]) ptr <= win_idx;
        else if (eoi_hit)       ptr <= eoi_idx;
      end
      if (wr_en) begin
        case (wr_addr)
          3'd0:    imr   <= wr_data[N_IRQ-1:0];
          3'd1:    trig  <= wr_data[N_IRQ-1:0];
          3'd2:    vbase <= wr_data[VEC_W-1:0];
          3'd3:    mode  <= wr_data[1:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      lat_idx      <= LAST;
      int_out      <= 1'b0;
      vector_out   <= '0;
      vector_valid <= 1'b0;
    end else begin
      int_out      <= (state == S_IDLE) && !inta && req;
      vector_valid <= (state == S_ACK1) && inta;
      case (state)
        S_IDLE: if (inta) begin
          state   <= S_ACK1;
          lat_idx <= req ? win_idx : LAST;
        end
        S_ACK1: if (inta) begin
          state      <= S_VEC;
          vector_out <= vbase + VEC_W'(lat_idx);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_addr)
      3'd0:    rd_data = 32'(imr);
      3'd1:    rd_data = 32'(trig);
      3'd2:    rd_data = 32'(vbase);
      3'd3:    rd_data = {30'b0, mode};
      3'd4:    rd_data = 32'(irr);
      3'd5:    rd_data = 32'(isr);
      3'd6:    rd_data = {30'b0, state};
      default: rd_data = '0;
    endcase
  end

endmodule
